red_pitaya_fads_sorter: RTL

RED_PITAYA_FADS_SORTER -- requirements
Module: red_pitaya_fads_sorter

---
 rtl/red_pitaya_fads_pkg.sv | 27 ++
 rtl/red_pitaya_fads_satcnt.sv | 26 ++
 rtl/red_pitaya_fads_sorter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_fads_pkg.sv
// rtl/red_pitaya_fads_pkg.sv - shared FSM encoding and register map for the FADS sorter
// Purpose: state codes (also exposed through STATUS) and sys-bus register offsets
//          decoded on sys_addr[19:0].
package red_pitaya_fads_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUAL  = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_DEAD  = 3'd4
    } fads_state_t;

    localparam logic [19:0] REG_CTRL     = 20'h00;
    localparam logic [19:0] REG_DELAY    = 20'h04;
    localparam logic [19:0] REG_WIDTH    = 20'h08;
    localparam logic [19:0] REG_DEAD     = 20'h0C;
    localparam logic [19:0] REG_TRIG_CNT = 20'h10;
    localparam logic [19:0] REG_SORT_CNT = 20'h14;
    localparam logic [19:0] REG_DROP_CNT = 20'h18;
    localparam logic [19:0] REG_STATUS   = 20'h1C;
    localparam logic [19:0] REG_MINW     = 20'h20;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

endpackage

// File: rtl/red_pitaya_fads_satcnt.sv
// rtl/red_pitaya_fads_satcnt.sv - saturating event counter with synchronous clear
// Purpose: counts inc pulses, sticks at all-ones; clr wins over inc in the same cycle.
// Ports:   clk, rst (async, active-high), clr, inc, cnt[CW-1:0].
module red_pitaya_fads_satcnt #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] ONE = CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// rtl/red_pitaya_fads_sorter.sv - FADS droplet sorter: trigger edge -> delayed ASG pulse
// Purpose: on a rising sort_trig_i edge (while enabled) wait DELAY cycles, drive
//          asg_trig_o for max(WIDTH,1) cycles, then hold off for DEAD cycles.
//          Edges arriving while busy are counted as drops and discarded.
// Ports:   adc_clk_i / adc_rst_i (async, active-high), sort_trig_i, asg_trig_o, busy_o,
//          sys_* system-bus register responder (ack one cycle after wen/ren).
// Option:  FADS_SORTER_QUAL_EN adds MINW (0x20) and a QUAL state requiring the trigger
//          to stay high MINW cycles before the delay starts.
module red_pitaya_fads_sorter
    import red_pitaya_fads_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        sort_trig_i,
    output logic        asg_trig_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    localparam logic [CW-1:0] ONE = CW'(1);

    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // configuration registers
    logic          enable;
    logic [CW-1:0] delay_r;
    logic [CW-1:0] width_r;
    logic [CW-1:0] dead_r;

    // working copies latched when an operation starts
    logic [CW-1:0] w_delay;
    logic [CW-1:0] w_width;
    logic [CW-1:0] w_dead;
    logic [CW-1:0] cnt;

`ifdef FADS_SORTER_QUAL_EN
    logic [CW-1:0] minw_r;
    logic [CW-1:0] w_minw;
`endif

    fads_state_t   state;
    logic          trig_q;
    logic          trig_edge;
    logic          clr;
    logic          trig_inc;
    logic          drop_inc;
    logic          sort_inc;
    logic          qual_path;
    logic          qual_done;
    logic [CW-1:0] trig_cnt;
    logic [CW-1:0] sort_cnt;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign unused_bits = ^{sys_sel, sys_addr[31:20]};

    assign trig_edge = sort_trig_i & ~trig_q;
    assign clr       = sys_wen & (sys_addr[19:0] == REG_CTRL) & sys_wdata[CTRL_CLEAR_BIT];
    assign trig_inc  = trig_edge & enable;
    assign drop_inc  = trig_inc & (state != ST_IDLE);
    assign busy_o    = (state != ST_IDLE);
    assign sys_err   = 1'b0;

`ifdef FADS_SORTER_QUAL_EN
    // MINW of 0 or 1 needs no qualification: E0 itself is the first high cycle
    assign qual_path = (minw_r > ONE);
    // cnt holds the number of high cycles seen so far, including E0
    assign qual_done = ((cnt + ONE) >= w_minw);
`else
    assign qual_path = 1'b0;
    assign qual_done = 1'b0;
`endif

    // PULSE entry, mirrored from the FSM transitions below
    always_comb begin
        sort_inc = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE:  sort_inc = trig_edge & ~qual_path & (delay_r == '0);
                ST_QUAL:  sort_inc = sort_trig_i & qual_done & (w_delay == '0);
                ST_DELAY: sort_inc = (cnt == ONE);
                default:  sort_inc = 1'b0;
            endcase
        end
    end

    // asg_trig_o follows the PULSE state one cycle late, which gives the
    // DELAY+1 offset from E0 and lets DELAY=0 go straight to PULSE at E0.
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            w_delay    <= '0;
            w_width    <= '0;
            w_dead     <= '0;
`ifdef FADS_SORTER_QUAL_EN
            w_minw     <= '0;
`endif
            asg_trig_o <= 1'b0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            asg_trig_o <= 1'b0;
        end else begin
            asg_trig_o <= (state == ST_PULSE);
            case (state)
                ST_IDLE: begin
                    if (trig_edge) begin
                        w_delay <= delay_r;
                        w_width <= width_r;
                        w_dead  <= dead_r;
`ifdef FADS_SORTER_QUAL_EN
                        w_minw  <= minw_r;
`endif
                        if (qual_path) begin
                            state <= ST_QUAL;
                            cnt   <= ONE;
                        end else if (delay_r == '0) begin
                            state <= ST_PULSE;
                            cnt   <= at_least_one(width_r);
                        end else begin
                            state <= ST_DELAY;
                            cnt   <= delay_r;
                        end
                    end
                end
                ST_QUAL: begin
                    if (!sort_trig_i) begin
                        state <= ST_IDLE;
                    end else if (qual_done) begin
                        if (w_delay == '0) begin
                            state <= ST_PULSE;
                            cnt   <= at_least_one(w_width);
                        end else begin
                            state <= ST_DELAY;
                            cnt   <= w_delay;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_DELAY: begin
                    if (cnt == ONE) begin
                        state <= ST_PULSE;
                        cnt   <= at_least_one(w_width);
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt == ONE) begin
                        if (w_dead == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DEAD;
                            cnt   <= w_dead;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_DEAD: begin
                    if (cnt == ONE) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (sys_addr[19:0])
            REG_CTRL:     rd_mux = {31'd0, enable};
            REG_DELAY:    rd_mux = 32'(delay_r);
            REG_WIDTH:    rd_mux = 32'(width_r);
            REG_DEAD:     rd_mux = 32'(dead_r);
            REG_TRIG_CNT: rd_mux = 32'(trig_cnt);
            REG_SORT_CNT: rd_mux = 32'(sort_cnt);
            REG_DROP_CNT: rd_mux = 32'(drop_cnt);
            REG_STATUS:   rd_mux = {29'd0, state};
`ifdef FADS_SORTER_QUAL_EN
            REG_MINW:     rd_mux = 32'(minw_r);
`endif
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            enable    <= 1'b0;
            delay_r   <= '0;
            width_r   <= '0;
            dead_r    <= '0;
`ifdef FADS_SORTER_QUAL_EN
            minw_r    <= '0;
`endif
            trig_q    <= 1'b0;
            sys_ack   <= 1'b0;
            sys_rdata <= 32'd0;
        end else begin
            trig_q    <= sort_trig_i;
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rd_mux : 32'd0;
            if (sys_wen) begin
                case (sys_addr[19:0])
                    REG_CTRL:  enable  <= sys_wdata[CTRL_ENABLE_BIT];
                    REG_DELAY: delay_r <= CW'(sys_wdata);
                    REG_WIDTH: width_r <= CW'(sys_wdata);
                    REG_DEAD:  dead_r  <= CW'(sys_wdata);
`ifdef FADS_SORTER_QUAL_EN
                    REG_MINW:  minw_r  <= CW'(sys_wdata);
`endif
                    default: ;
                endcase
            end
        end
    end

    red_pitaya_fads_satcnt #(.CW(CW)) u_trig_cnt (
        .clk (adc_clk_i),
        .rst (adc_rst_i),
        .clr (clr),
        .inc (trig_inc),
        .cnt (trig_cnt)
    );

    red_pitaya_fads_satcnt #(.CW(CW)) u_sort_cnt (
        .clk (adc_clk_i),
        .rst (adc_rst_i),
        .clr (clr),
        .inc (sort_inc),
        .cnt (sort_cnt)
    );

    red_pitaya_fads_satcnt #(.CW(CW)) u_drop_cnt (
        .clk (adc_clk_i),
        .rst (adc_rst_i),
        .clr (clr),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

endmodule
